// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive blocks.
//   state_t    : frame FSM encoding (PARITY is only reached when parity is built in)
//   LINE_IDLE  : level of the line between frames
//   START_BIT  : level of the start bit
//   parity_of  : XOR of up to 16 data bits, optionally inverted for odd parity
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [15:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/serial_tx_buffered_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with occupancy counter.
// The head word is presented on dout while the FIFO is non-empty
// (first-word fall-through), so a pop can consume it on the same edge.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, din       : write strobe and data; ignored when full
//   pop, dout       : read strobe and head word; ignored when empty
//   full, empty     : status from the registered count
//   level           : current occupancy, 0..DEPTH
module sync_fifo
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Both qualifiers use the pre-edge count: a push while full is refused
    // even if a pop frees a slot on the same edge.
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign level = count;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx_buffered.sv
// serial_tx_buffered: FIFO-buffered asynchronous serial transmitter.
// Frame = start bit, WIDTH data bits LSB first, [parity], STOP_BITS stop bits,
// each bit DIVIDER clocks long. Queued words go out back-to-back.
// Optional feature: define SERIAL_TX_PARITY_EN to add a parity bit and the
// ODD_PARITY parameter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   ce, data   : write strobe and word to queue
//   tx         : registered serial line, idle high
//   busy       : FIFO non-empty or frame in progress
//   full/level : FIFO status
//   overflow   : one-cycle pulse after a write that found the FIFO full
module serial_tx_buffered
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIVIDER    = 2,
    parameter int STOP_BITS  = 1,
    parameter int DEPTH      = 4
`ifdef SERIAL_TX_PARITY_EN
    , parameter int ODD_PARITY = 0
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic [WIDTH-1:0]       data,
    output logic                   tx,
    output logic                   busy,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIVIDER - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] head;
    logic             empty;
    logic             div_last;
    logic             frame_end;
    logic             pop;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_bit;
`endif

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ce),
        .pop   (pop),
        .din   (data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign div_last  = (div_cnt == DIV_LAST);
    // bit_cnt doubles as the stop-bit counter while in STOP.
    assign frame_end = (state == STOP) && div_last && (bit_cnt == STOP_LAST);
    // Pop from IDLE, or on the last stop cycle so the next start follows with no gap.
    assign pop       = !empty && ((state == IDLE) || frame_end);
    assign busy      = (state != IDLE) || (level != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx       <= LINE_IDLE;
            overflow <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            overflow <= ce && full;

            // tx follows the state of the previous cycle, which yields the
            // two-cycle push-to-start latency.
            case (state)
                START:   tx <= START_BIT;
                DATA:    tx <= shift[0];
`ifdef SERIAL_TX_PARITY_EN
                PARITY:  tx <= par_bit;
`endif
                default: tx <= LINE_IDLE;
            endcase

            if (pop) begin
                shift   <= head;
                div_cnt <= '0;
                bit_cnt <= '0;
                state   <= START;
`ifdef SERIAL_TX_PARITY_EN
                par_bit <= parity_of(16'(head), ODD_PARITY != 0);
`endif
            end else begin
                case (state)
                    START: begin
                        if (div_last) begin
                            div_cnt <= '0;
                            state   <= DATA;
                        end else
                            div_cnt <= div_cnt + 1'b1;
                    end
                    DATA: begin
                        if (div_last) begin
                            div_cnt <= '0;
                            shift   <= {1'b0, shift[WIDTH-1:1]};
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                                state   <= PARITY;
`else
                                state   <= STOP;
`endif
                            end else
                                bit_cnt <= bit_cnt + 1'b1;
                        end else
                            div_cnt <= div_cnt + 1'b1;
                    end
`ifdef SERIAL_TX_PARITY_EN
                    PARITY: begin
                        if (div_last) begin
                            div_cnt <= '0;
                            state   <= STOP;
                        end else
                            div_cnt <= div_cnt + 1'b1;
                    end
`endif
                    STOP: begin
                        if (div_last) begin
                            div_cnt <= '0;
                            if (bit_cnt == STOP_LAST) begin
                                bit_cnt <= '0;
                                state   <= IDLE;
                            end else
                                bit_cnt <= bit_cnt + 1'b1;
                        end else
                            div_cnt <= div_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_tx_buffered.sv
// Self-checking bench for serial_tx_buffered. Line, busy, level and overflow
// are logged every falling edge; frames are then checked against expected
// bit patterns (bit i of a pattern = line level during bit time i).
module tb_serial_tx_buffered;

`ifdef SERIAL_TX_PARITY_EN
    localparam int FLEN  = 11;   // bit times per frame, default instance
    localparam int FLEN2 = 11;   // WIDTH=7, STOP_BITS=2 instance
`else
    localparam int FLEN  = 10;
    localparam int FLEN2 = 10;
`endif
    localparam int F1   = FLEN * 2;
    localparam int F2   = FLEN2 * 3;
    localparam int LOGN = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce, ce2, ce3;
    logic [7:0] data, data3;
    logic [6:0] data2;
    logic       tx, busy, full, overflow;
    logic [2:0] level;
    logic       tx2, busy2, full2, overflow2;
    logic [2:0] level2;
    logic       tx3, busy3, full3, overflow3;
    logic [2:0] level3;

    always #5 clk = ~clk;

    serial_tx_buffered #(.WIDTH(8), .DIVIDER(2), .STOP_BITS(1), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .ce(ce), .data(data), .tx(tx), .busy(busy),
        .full(full), .level(level), .overflow(overflow));

    serial_tx_buffered #(.WIDTH(7), .DIVIDER(3), .STOP_BITS(2), .DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .ce(ce2), .data(data2), .tx(tx2), .busy(busy2),
        .full(full2), .level(level2), .overflow(overflow2));

`ifdef SERIAL_TX_PARITY_EN
    serial_tx_buffered #(.WIDTH(8), .DIVIDER(2), .STOP_BITS(1), .DEPTH(4), .ODD_PARITY(1)) dut3 (
        .clk(clk), .reset(reset), .ce(ce3), .data(data3), .tx(tx3), .busy(busy3),
        .full(full3), .level(level3), .overflow(overflow3));
`else
    assign tx3 = 1'b1; assign busy3 = 1'b0; assign full3 = 1'b0;
    assign level3 = '0; assign overflow3 = 1'b0;
`endif

    logic       tx_log [3][LOGN];
    logic       bz_log [3][LOGN];
    logic       ov_log [LOGN];
    logic [2:0] lv_log [LOGN];
    int         cyc = 0;

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            tx_log[0][cyc] <= tx;   bz_log[0][cyc] <= busy;
            tx_log[1][cyc] <= tx2;  bz_log[1][cyc] <= busy2;
            tx_log[2][cyc] <= tx3;  bz_log[2][cyc] <= busy3;
            ov_log[cyc]    <= overflow;
            lv_log[cyc]    <= level;
        end
        cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Line at st-1 must be high (idle or previous stop), then the pattern.
    function automatic logic frame_ok(input int d, input int st, input logic [15:0] fr,
                                      input int flen, input int div);
        if (st < 1 || st + flen * div > LOGN) return 1'b0;
        if (tx_log[d][st-1] !== 1'b1) return 1'b0;
        for (int i = 0; i < flen; i++)
            for (int j = 0; j < div; j++)
                if (tx_log[d][st + i*div + j] !== fr[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int run_len(input int d, input int st);
        int n = 0;
        while (st + n < LOGN && bz_log[d][st + n] === 1'b1) n++;
        return n;
    endfunction

    // Reference frame pattern for the default 8-bit instance (even parity if built in).
    function automatic logic [15:0] mkfr8(input logic [7:0] d);
`ifdef SERIAL_TX_PARITY_EN
        return {5'b0, 1'b1, ^d, d, 1'b0};
`else
        return {6'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    typedef struct {
        logic [7:0]  d;
        logic [15:0] fr;   // hand-written: stop | [parity] | data | start
    } vec_t;

    vec_t vt [5];

    initial begin
        int t, ovc, lmax, lowc;
        logic [15:0] fr2;

`ifdef SERIAL_TX_PARITY_EN
        vt[0] = '{8'hA5, 16'b00000_1_0_10100101_0};
        vt[1] = '{8'h00, 16'b00000_1_0_00000000_0};
        vt[2] = '{8'hFF, 16'b00000_1_0_11111111_0};
        vt[3] = '{8'h3C, 16'b00000_1_0_00111100_0};
        vt[4] = '{8'h07, 16'b00000_1_1_00000111_0};
        fr2   = 16'b00000_11_0_1010101_0;
`else
        vt[0] = '{8'hA5, 16'b000000_1_10100101_0};
        vt[1] = '{8'h00, 16'b000000_1_00000000_0};
        vt[2] = '{8'hFF, 16'b000000_1_11111111_0};
        vt[3] = '{8'h3C, 16'b000000_1_00111100_0};
        vt[4] = '{8'h07, 16'b000000_1_00000111_0};
        fr2   = 16'b000000_11_1010101_0;
`endif

        reset = 1'b1; ce = 0; ce2 = 0; ce3 = 0; data = 0; data2 = 0; data3 = 0;
        tick(3);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_full", full, 0);
        chk("reset_level", level, 0);
        chk("reset_overflow", overflow, 0);
        reset = 1'b0;
        tick(2);

        // Single frames from the table
        foreach (vt[k]) begin
            ce = 1; data = vt[k].d;
            tick(1); t = cyc; ce = 0;
            tick(F1 + 6);
            chk($sformatf("frame_%02h", vt[k].d), frame_ok(0, t + 2, vt[k].fr, FLEN, 2), 1);
            chk($sformatf("busy_len_%02h", vt[k].d), run_len(0, t), F1 + 1);
            chk($sformatf("level_after_push_%02h", vt[k].d), lv_log[t], 1);
        end

        // Three words back-to-back: no idle gap, one pop overlaps the second push
        ce = 1; data = 8'h01; tick(1); t = cyc;
        data = 8'h02; tick(1);
        data = 8'h03; tick(1); ce = 0;
        tick(3 * F1 + 8);
        chk("b2b_frame0", frame_ok(0, t + 2,          mkfr8(8'h01), FLEN, 2), 1);
        chk("b2b_frame1", frame_ok(0, t + 2 + F1,     mkfr8(8'h02), FLEN, 2), 1);
        chk("b2b_frame2", frame_ok(0, t + 2 + 2 * F1, mkfr8(8'h03), FLEN, 2), 1);
        chk("b2b_busy_len", run_len(0, t), 3 * F1 + 1);
        lmax = 0;
        for (int i = t; i < t + 3 * F1; i++) if (int'(lv_log[i]) > lmax) lmax = int'(lv_log[i]);
        chk("b2b_level_max", lmax, 2);

        // Overflow: one frame in flight, then five pushes into the empty FIFO
        ce = 1; data = 8'h11; tick(1); t = cyc; ce = 0;
        tick(4);
        ce = 1;
        for (int k = 0; k < 5; k++) begin
            data = 8'h21 + 8'(k);
            tick(1);
            if (k == 3) chk("ovf_full_after_4", full, 1);
        end
        ce = 0;
        tick(6 * F1 + 10);
        ovc = 0;
        for (int i = t; i < t + F1; i++) if (ov_log[i] === 1'b1) ovc++;
        chk("ovf_pulse_count", ovc, 1);
        chk("ovf_frame0", frame_ok(0, t + 2,          mkfr8(8'h11), FLEN, 2), 1);
        chk("ovf_frame1", frame_ok(0, t + 2 + F1,     mkfr8(8'h21), FLEN, 2), 1);
        chk("ovf_frame4", frame_ok(0, t + 2 + 4 * F1, mkfr8(8'h24), FLEN, 2), 1);
        chk("ovf_busy_len", run_len(0, t), 5 * F1 + 1);
        lowc = 0;
        for (int i = t + 2 + 5 * F1; i < t + 2 + 6 * F1; i++) if (tx_log[0][i] !== 1'b1) lowc++;
        chk("ovf_no_sixth_frame", lowc, 0);

        // Reset in the middle of data bit 3 of 8'hFF with two more words queued
        ce = 1; data = 8'hFF; tick(1); t = cyc;
        data = 8'h12; tick(1);
        data = 8'h34; tick(1); ce = 0;
        tick(8);
        chk("midreset_level_before", level, 2);
        #1 reset = 1'b1;
        #1;
        chk("midreset_tx", tx, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_level", level, 0);
        #2 reset = 1'b0;
        tick(1);
        t = cyc;
        tick(3 * F1);
        lowc = 0;
        for (int i = t; i < t + 3 * F1 - 2; i++)
            if (tx_log[0][i] !== 1'b1 || bz_log[0][i] !== 1'b0) lowc++;
        chk("midreset_quiet_after", lowc, 0);

        // WIDTH=7, DIVIDER=3, STOP_BITS=2 instance
        ce2 = 1; data2 = 7'h55; tick(1); t = cyc; ce2 = 0;
        tick(F2 + 8);
        chk("w7_frame", frame_ok(1, t + 2, fr2, FLEN2, 3), 1);
        chk("w7_busy_len", run_len(1, t), F2 + 1);
        lowc = 0;
        for (int i = t + 2 + F2 - 6; i < t + 2 + F2; i++) if (tx_log[1][i] === 1'b1) lowc++;
        chk("w7_stop_high_cycles", lowc, 6);

`ifdef SERIAL_TX_PARITY_EN
        // Odd parity instance: 8'h07 has three ones, so the parity bit is 0
        ce3 = 1; data3 = 8'h07; tick(1); t = cyc; ce3 = 0;
        tick(F1 + 6);
        chk("odd_parity_frame", frame_ok(2, t + 2, 16'b00000_1_0_00000111_0, FLEN, 2), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
